// File: rtl/traffic.sv
// Three-phase traffic-light Moore FSM (RED -> GREEN -> YELLOW -> RED) with a per-state minimum dwell.
// Define TRAFFIC_AUTO_YELLOW_EN to make YELLOW fall back to RED on its dwell alone, ignoring in.
module traffic #(
  parameter int unsigned RED_MIN    = 1,
  parameter int unsigned GREEN_MIN  = 1,
  parameter int unsigned YELLOW_MIN = 1
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       in,
  output logic       z,
  output logic       red,
  output logic       green,
  output logic       yellow,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_RED     = 2'b00,
    S_GREEN   = 2'b01,
    S_YELLOW  = 2'b10,
    S_ILLEGAL = 2'b11
  } state_e;

  localparam logic [7:0] RED_LAST    = 8'(RED_MIN - 1);
  localparam logic [7:0] GREEN_LAST  = 8'(GREEN_MIN - 1);
  localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_MIN - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] last;
  logic       dwell_met;
  logic       advance;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    last      = RED_LAST;
    advance   = 1'b0;
    state_d   = state_q;
    cnt_d     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    case (state_q)
      S_GREEN:  last = GREEN_LAST;
      S_YELLOW: last = YELLOW_LAST;
      default:  last = RED_LAST;
    endcase

    dwell_met = (cnt_q >= last);
    advance   = in && dwell_met;
`ifdef TRAFFIC_AUTO_YELLOW_EN
    if (state_q == S_YELLOW) advance = dwell_met;
`endif

    case (state_q)
      S_RED:    if (advance) state_d = S_GREEN;
      S_GREEN:  if (advance) state_d = S_YELLOW;
      S_YELLOW: if (advance) state_d = S_RED;
      default:  state_d = S_RED;  // illegal code recovers unconditionally
    endcase

    if (state_d != state_q) cnt_d = 8'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= S_RED;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Lamps decode only the state register; the illegal code reads as RED.
  assign green  = (state_q == S_GREEN);
  assign yellow = (state_q == S_YELLOW);
  assign red    = !(green || yellow);
  assign z      = green;
  assign state  = red ? S_RED : state_q;

endmodule

// File: tb/tb_traffic.sv
// Directed bench for traffic: a default-parameter instance and a GREEN_MIN=3 instance share clock and reset.
module tb_traffic;

  logic       clk = 1'b0;
  logic       areset;
  logic       in_a, in_b;
  logic       z_a, red_a, green_a, yellow_a;
  logic       z_b, red_b, green_b, yellow_b;
  logic [1:0] state_a, state_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  traffic u_def (
    .clk    (clk),
    .areset (areset),
    .in     (in_a),
    .z      (z_a),
    .red    (red_a),
    .green  (green_a),
    .yellow (yellow_a),
    .state  (state_a)
  );

  traffic #(.GREEN_MIN(3)) u_g3 (
    .clk    (clk),
    .areset (areset),
    .in     (in_b),
    .z      (z_b),
    .red    (red_b),
    .green  (green_b),
    .yellow (yellow_b),
    .state  (state_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected lamps follow from the expected state code.
  task automatic chk_out(input string tag, input logic [1:0] exp_st, input logic [1:0] st,
                         input logic r, input logic g, input logic y, input logic zz);
    logic [3:0] exp_l;
    exp_l = {exp_st == 2'b00, exp_st == 2'b01, exp_st == 2'b10, exp_st == 2'b01};
    chk({tag, ".state"}, {6'd0, st}, {6'd0, exp_st});
    chk({tag, ".lamps"}, {4'd0, r, g, y, zz}, {4'd0, exp_l});
  endtask

  task automatic chk_a(input string tag, input logic [1:0] exp_st);
    chk_out(tag, exp_st, state_a, red_a, green_a, yellow_a, z_a);
  endtask

  task automatic chk_b(input string tag, input logic [1:0] exp_st);
    chk_out(tag, exp_st, state_b, red_b, green_b, yellow_b, z_b);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    areset = 1'b1;
    in_a   = 1'b0;
    in_b   = 1'b0;
    #2;
    chk_a("reset_a", 2'b00);
    chk_b("reset_b", 2'b00);

    tick(1);
    areset = 1'b0;
    tick(1);
    chk_a("post_reset_hold", 2'b00);

    // Default instance: three advances, then hold.
    in_a = 1'b1;
    tick(1); chk_a("adv1_green", 2'b01);
    tick(1); chk_a("adv2_yellow", 2'b10);
    tick(1); chk_a("adv3_red", 2'b00);
    in_a = 1'b0;
    tick(1); chk_a("hold_red1", 2'b00);
    tick(3); chk_a("hold_red4", 2'b00);
    chk_b("g3_idle_red", 2'b00);

    // GREEN_MIN=3: RED->GREEN on first edge, then two holding edges, YELLOW on the 3rd.
    in_b = 1'b1;
    tick(1); chk_b("g3_enter_green", 2'b01);
    tick(1); chk_b("g3_green_e1", 2'b01);
    tick(1); chk_b("g3_green_e2", 2'b01);
    tick(1); chk_b("g3_yellow_e3", 2'b10);
    in_b = 1'b0;
    tick(1); chk_b("g3_yellow_hold", 2'b10);
    in_b = 1'b1;
    tick(1); chk_b("g3_back_red", 2'b00);
    tick(1); chk_b("g3_green_again", 2'b01);
    in_b = 1'b0;
    tick(257); chk_b("g3_green_long_hold", 2'b01);
    // Dwell counter saturated at 255, so the first request is accepted at once.
    in_b = 1'b1;
    tick(1); chk_b("g3_sat_advance", 2'b10);
    in_b = 1'b0;

    // Asynchronous reset mid-GREEN (default) and mid-YELLOW (GREEN_MIN=3).
    in_a = 1'b1;
    tick(1); chk_a("pre_abort_green", 2'b01);
    in_a = 1'b0;
    #2;
    areset = 1'b1;
    #1;
    chk_a("abort_green_async", 2'b00);
    chk_b("abort_yellow_async", 2'b00);
    in_a = 1'b1;
    tick(1); chk_a("reset_ignores_in", 2'b00);
    areset = 1'b0;
    tick(1); chk_a("first_edge_after_reset", 2'b01);
    in_a = 1'b0;
    tick(1); chk_a("green_hold", 2'b01);

    // Illegal state code reads as RED and recovers to RED on the next edge.
    force u_def.state_q = 2'b11;
    #1;
    chk_a("illegal_reads_red", 2'b00);
    release u_def.state_q;
    in_a = 1'b1;
    tick(1); chk_a("illegal_recover", 2'b00);
    chk("illegal_cnt_clear", u_def.cnt_q, 8'd0);
    tick(1); chk_a("after_recover_adv", 2'b01);
    in_a = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
